seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Sequential ALU with valid/ready handshakes on request and result.
//             Single-cycle ops: addu, subu, and, sll, srl.
//             Optional iterative shift-add multu (one multiplier bit per cycle),
//             enabled by defining the macro SEQ_ALU_MULT_EN. Without it, multu
//             completes as an illegal request and hi stays at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Src1,
   input  logic [WIDTH-1:0] Src2,
   input  logic [SHW-1:0]   Shamt,
   input  logic [5:0]       Funct,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             Zero,
   output logic             illegal
);

   // Operation encodings
   localparam logic [5:0] c_addu  = 6'b001001;
   localparam logic [5:0] c_subu  = 6'b001010;
   localparam logic [5:0] c_and   = 6'b010001;
   localparam logic [5:0] c_sll   = 6'b100001;
   localparam logic [5:0] c_srl   = 6'b100010;
`ifdef SEQ_ALU_MULT_EN
   localparam logic [5:0] c_multu = 6'b011001;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi;
   logic             r_zero;
   logic             r_illegal;

   logic [WIDTH-1:0] w_alu;
   logic             w_single;
   logic             w_is_mult;
   logic             w_accept;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign hi        = r_hi;
   assign Zero      = r_zero;
   assign illegal   = r_illegal;

   // Operands are only sampled on the edge where a request is accepted.
   assign w_accept  = in_valid && (r_state == IDLE);

   // Decode Funct and evaluate the single-cycle operations.
   always_comb begin
      w_alu     = '0;
      w_single  = 1'b1;
      w_is_mult = 1'b0;
      case (Funct)
         c_addu:  w_alu = Src1 + Src2;
         c_subu:  w_alu = Src1 - Src2;
         c_and:   w_alu = Src1 & Src2;
         c_sll:   w_alu = Src1 << Shamt;
         c_srl:   w_alu = Src1 >> Shamt;
`ifdef SEQ_ALU_MULT_EN
         c_multu: begin
            w_single  = 1'b0;
            w_is_mult = 1'b1;
         end
`endif
         default: w_single = 1'b0;
      endcase
   end

`ifdef SEQ_ALU_MULT_EN
   // Number of shift-add steps; BUSY holds one extra edge to publish.
   localparam logic [SHW:0] c_mul_steps = (SHW+1)'(WIDTH);

   // Product register: upper half accumulates, lower half holds the
   // not-yet-consumed multiplier bits, shifting right one bit per step.
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic [SHW:0]       r_count;
   logic [WIDTH:0]     w_psum;
   logic               w_mul_step;
   logic               w_mul_done;

   assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
   assign w_mul_step = (r_state == BUSY) && (r_count != c_mul_steps);
   assign w_mul_done = (r_state == BUSY) && (r_count == c_mul_steps);

   // Iterative shift-add multiplier datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prod  <= '0;
         r_mcand <= '0;
         r_count <= '0;
      end else if (w_accept && w_is_mult) begin
         r_prod  <= {{WIDTH{1'b0}}, Src2};
         r_mcand <= Src1;
         r_count <= '0;
      end else if (w_mul_step) begin
         r_prod  <= {w_psum, r_prod[WIDTH-1:1]};
         r_count <= r_count + 1'b1;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_next_state = w_is_mult ? BUSY : DONE;
            end
         end
         BUSY: begin
`ifdef SEQ_ALU_MULT_EN
            if (w_mul_done) begin
               w_next_state = DONE;
            end
`else
            w_next_state = IDLE;
`endif
         end
         DONE: begin
            if (out_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Result/flag registers: written only on a completion, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result  <= '0;
         r_hi      <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         if (w_single) begin
            r_result  <= w_alu;
            r_hi      <= '0;
            r_zero    <= (w_alu == '0);
            r_illegal <= 1'b0;
         end else if (!w_is_mult) begin
            // Unsupported op: keep the old values, refresh Zero from them.
            r_zero    <= ({r_hi, r_result} == '0);
            r_illegal <= 1'b1;
         end
      end
`ifdef SEQ_ALU_MULT_EN
      else if (w_mul_done) begin
         r_result  <= r_prod[WIDTH-1:0];
         r_hi      <= r_prod[2*WIDTH-1:WIDTH];
         r_zero    <= (r_prod == '0);
         r_illegal <= 1'b0;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Brief    : Directed self-checking bench for seq_alu (WIDTH = 32).
//             Follows SEQ_ALU_MULT_EN to pick the multu expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;

   localparam logic [5:0] F_ADDU  = 6'b001001;
   localparam logic [5:0] F_SUBU  = 6'b001010;
   localparam logic [5:0] F_AND   = 6'b010001;
   localparam logic [5:0] F_SLL   = 6'b100001;
   localparam logic [5:0] F_SRL   = 6'b100010;
   localparam logic [5:0] F_MULTU = 6'b011001;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] Src1      = '0;
   logic [WIDTH-1:0] Src2      = '0;
   logic [SHW-1:0]   Shamt     = '0;
   logic [5:0]       Funct     = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic             Zero;
   logic             illegal;

   int n_checks = 0;
   int n_fail   = 0;

   seq_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Src1      (Src1),
      .Src2      (Src2),
      .Shamt     (Shamt),
      .Funct     (Funct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .hi        (hi),
      .Zero      (Zero),
      .illegal   (illegal)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request for one edge, then scramble inputs to prove capture.
   task automatic start_op(input logic [5:0] f, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
      @(negedge clk);
      Funct    = f;
      Src1     = a;
      Src2     = b;
      Shamt    = sh;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      Src1     = $urandom;
      Src2     = $urandom;
      Shamt    = SHW'($urandom);
      Funct    = 6'b111111;
   endtask

   // Cycles from the accept edge until out_valid is seen (0 = timed out).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [5:0] f,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [SHW-1:0] sh, input int exp_lat,
                        input logic [WIDTH-1:0] exp_res, input logic [WIDTH-1:0] exp_hi,
                        input logic exp_zero, input logic exp_ill);
      int lat;
      start_op(f, a, b, sh);
      wait_done(lat);
      check({tag, "_lat"},     64'(lat),     64'(exp_lat));
      check({tag, "_result"},  64'(result),  64'(exp_res));
      check({tag, "_hi"},      64'(hi),      64'(exp_hi));
      check({tag, "_zero"},    64'(Zero),    64'(exp_zero));
      check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
      consume();
   endtask

   initial begin
      int  lat;
      logic seen;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_result",    64'(result),    64'd0);
      check("rst_hi",        64'(hi),        64'd0);
      check("rst_zero",      64'(Zero),      64'd1);
      check("rst_illegal",   64'(illegal),   64'd0);
      rst = 1'b0;

      // Single-cycle operations and wrap boundaries
      do_op("addu_wrap", F_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
      do_op("subu_neg",  F_SUBU, 32'd5,          32'd7,          5'd0, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
      do_op("sll_31",    F_SLL,  32'h0000_0001, 32'hDEAD_BEEF, 5'd31, 1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
      do_op("srl_31",    F_SRL,  32'h8000_0000, 32'h1234_5678, 5'd31, 1, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
      do_op("addu_5",    F_ADDU, 32'd2,          32'd3,          5'd0, 1, 32'h0000_0005, 32'h0, 1'b0, 1'b0);

      // Illegal Funct keeps result, then a legal AND clears illegal
      do_op("illegal_0", 6'b000000, 32'h1111_1111, 32'h2222_2222, 5'd3, 1, 32'h0000_0005, 32'h0, 1'b0, 1'b1);
      do_op("and_zero",  F_AND,  32'h0000_00F0, 32'h0000_000F, 5'd0, 1, 32'h0000_0000, 32'h0, 1'b1, 1'b0);

      // Multiply
`ifdef SEQ_ALU_MULT_EN
      do_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op("multu_x16", F_MULTU, 32'h1234_5678, 32'h0000_0010, 5'd0, 33, 32'h2345_6780, 32'h0000_0001, 1'b0, 1'b0);
`else
      do_op("multu_off", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1, 32'h0000_0000, 32'h0, 1'b1, 1'b1);
`endif

      // Back-pressure: result held, no accept while DONE
      start_op(F_ADDU, 32'h10, 32'h20, 5'd0);
      wait_done(lat);
      check("bp_lat", 64'(lat), 64'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         Funct    = F_ADDU;
         Src1     = $urandom;
         Src2     = $urandom;
         @(negedge clk);
         check("bp_result",    64'(result),    64'h30);
         check("bp_in_ready",  64'(in_ready),  64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      // Request offered on the consuming edge must be ignored
      in_valid  = 1'b1;
      Funct     = F_ADDU;
      Src1      = 32'd1;
      Src2      = 32'd1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check("bp_after_in_ready",  64'(in_ready),  64'd1);
      check("bp_after_out_valid", 64'(out_valid), 64'd0);
      check("bp_after_result",    64'(result),    64'h30);

      // Reset in the middle of an operation aborts it
      start_op(F_MULTU, 32'd3, 32'd5, 5'd0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #2;
      check("abort_out_valid_async", 64'(out_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_result",   64'(result),   64'd0);
      check("abort_hi",       64'(hi),       64'd0);
      check("abort_zero",     64'(Zero),     64'd1);
      check("abort_illegal",  64'(illegal),  64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_stale", 64'(seen), 64'd0);

      // Normal operation resumes
      do_op("post_abort", F_ADDU, 32'd1, 32'd1, 5'd0, 1, 32'h0000_0002, 32'h0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
